// File: rtl/spi_master_mopshub_if.sv
// Bus bundle for the MOPSHUB SPI master: byte handshake on the control
// side and the serial pins on the peripheral side.
// Optional macro SPI_MASTER_CS_EN adds the active-low chip select pin.
interface spi_master_mopshub_if;
    logic [7:0] i_TX_Byte;
    logic       i_TX_DV;
    logic       o_TX_Ready;
    logic       o_RX_DV;
    logic [7:0] o_RX_Byte;
    logic       o_SPI_Clk;
    logic       i_SPI_MISO;
    logic       o_SPI_MOSI;
`ifdef SPI_MASTER_CS_EN
    logic       o_SPI_CS_n;
`endif

    // Seen from the SPI master itself.
    modport master (
`ifdef SPI_MASTER_CS_EN
        output o_SPI_CS_n,
`endif
        input  i_TX_Byte,
        input  i_TX_DV,
        input  i_SPI_MISO,
        output o_TX_Ready,
        output o_RX_DV,
        output o_RX_Byte,
        output o_SPI_Clk,
        output o_SPI_MOSI
    );

    // Seen from the controller / peripheral side driving the master.
    modport slave (
`ifdef SPI_MASTER_CS_EN
        input  o_SPI_CS_n,
`endif
        output i_TX_Byte,
        output i_TX_DV,
        output i_SPI_MISO,
        input  o_TX_Ready,
        input  o_RX_DV,
        input  o_RX_Byte,
        input  o_SPI_Clk,
        input  o_SPI_MOSI
    );
endinterface

// File: rtl/spi_master_mopshub.sv
// Byte-oriented SPI master for MOPSHUB. Shifts one byte out on MOSI (MSB
// first) while shifting one byte in from MISO. SPI_MODE selects CPOL/CPHA,
// CLKS_PER_HALF_BIT sets the SCLK half-period in i_Clk cycles (>= 2).
// i_Rst_L is a synchronous, active-high reset despite its name.
// Optional macro SPI_MASTER_CS_EN adds o_SPI_CS_n with a half-bit setup
// delay before the first SCLK edge.
module spi_master_mopshub #(
    parameter int SPI_MODE          = 3,
    parameter int CLKS_PER_HALF_BIT = 4
) (
    input  logic                  i_Clk,
    input  logic                  i_Rst_L,
    spi_master_mopshub_if.master  bus
);

    localparam logic [1:0] MODE = 2'(SPI_MODE);
    localparam logic       CPOL = MODE[1];
    localparam logic       CPHA = MODE[0];

    localparam int unsigned CW = $clog2(2 * CLKS_PER_HALF_BIT);
    localparam logic [CW-1:0] LEAD_CNT  = CW'(CLKS_PER_HALF_BIT - 1);
    localparam logic [CW-1:0] TRAIL_CNT = CW'(2 * CLKS_PER_HALF_BIT - 1);

    typedef enum logic {IDLE, BUSY} state_t;

    state_t          state;
    logic [CW-1:0]   half_cnt;
    logic [3:0]      edge_cnt;
    logic [7:0]      tx_shift;
    logic [7:0]      rx_shift;
    logic [7:0]      rx_next;
    logic            spi_clk;
    logic            mosi;
    logic            tx_ready;
    logic            rx_dv;
    logic [7:0]      rx_byte;
    logic            setup_active;
    logic            lead_edge;
    logic            trail_edge;
    logic            last_edge;

`ifdef SPI_MASTER_CS_EN
    localparam int unsigned SW = $clog2(CLKS_PER_HALF_BIT + 1);
    localparam logic [SW-1:0] SETUP_CYCLES = SW'(CLKS_PER_HALF_BIT);
    logic [SW-1:0]   setup_cnt;
    logic            cs_n;
`endif

    // Edge decode from the half-bit counter; the counter is frozen during CS setup.
    always_comb begin
        setup_active = 1'b0;
`ifdef SPI_MASTER_CS_EN
        setup_active = (setup_cnt != '0);
`endif
        lead_edge  = (state == BUSY) && !setup_active && (half_cnt == LEAD_CNT);
        trail_edge = (state == BUSY) && !setup_active && (half_cnt == TRAIL_CNT);
        last_edge  = trail_edge && (edge_cnt == 4'd15);
        rx_next    = {rx_shift[6:0], bus.i_SPI_MISO};
    end

    // Transfer FSM: SCLK generation, MOSI launch, MISO capture and handshake.
    always_ff @(posedge i_Clk) begin
        if (i_Rst_L) begin
            state    <= IDLE;
            half_cnt <= '0;
            edge_cnt <= '0;
            tx_shift <= '0;
            rx_shift <= '0;
            spi_clk  <= CPOL;
            mosi     <= 1'b0;
            tx_ready <= 1'b0;
            rx_dv    <= 1'b0;
            rx_byte  <= '0;
`ifdef SPI_MASTER_CS_EN
            setup_cnt <= '0;
            cs_n      <= 1'b1;
`endif
        end else begin
            rx_dv <= 1'b0;
            case (state)
                IDLE: begin
                    spi_clk  <= CPOL;
                    tx_ready <= 1'b1;
                    half_cnt <= '0;
                    edge_cnt <= '0;
                    if (tx_ready && bus.i_TX_DV) begin
                        state    <= BUSY;
                        tx_ready <= 1'b0;
                        if (!CPHA) begin
                            // CPHA=0 presents bit7 before the first edge.
                            mosi     <= bus.i_TX_Byte[7];
                            tx_shift <= {bus.i_TX_Byte[6:0], 1'b0};
                        end else begin
                            tx_shift <= bus.i_TX_Byte;
                        end
`ifdef SPI_MASTER_CS_EN
                        cs_n      <= 1'b0;
                        setup_cnt <= SETUP_CYCLES;
`endif
                    end
                end

                BUSY: begin
`ifdef SPI_MASTER_CS_EN
                    if (setup_active) begin
                        setup_cnt <= setup_cnt - 1'b1;
                    end
`endif
                    if (!setup_active) begin
                        if (half_cnt == TRAIL_CNT) begin
                            half_cnt <= '0;
                        end else begin
                            half_cnt <= half_cnt + 1'b1;
                        end
                    end

                    if (lead_edge) begin
                        spi_clk  <= ~spi_clk;
                        edge_cnt <= edge_cnt + 4'd1;
                        if (CPHA) begin
                            mosi     <= tx_shift[7];
                            tx_shift <= {tx_shift[6:0], 1'b0};
                        end else begin
                            rx_shift <= rx_next;
                        end
                    end

                    if (trail_edge) begin
                        spi_clk <= ~spi_clk;
                        if (CPHA) begin
                            rx_shift <= rx_next;
                        end else if (!last_edge) begin
                            // No launch after the final bit, so MOSI holds bit0.
                            mosi     <= tx_shift[7];
                            tx_shift <= {tx_shift[6:0], 1'b0};
                        end

                        if (last_edge) begin
                            state    <= IDLE;
                            tx_ready <= 1'b1;
                            rx_dv    <= 1'b1;
                            // CPHA=1 captures bit0 on this very edge.
                            rx_byte  <= CPHA ? rx_next : rx_shift;
                            edge_cnt <= '0;
                            half_cnt <= '0;
`ifdef SPI_MASTER_CS_EN
                            cs_n     <= 1'b1;
`endif
                        end else begin
                            edge_cnt <= edge_cnt + 4'd1;
                        end
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

    assign bus.o_TX_Ready = tx_ready;
    assign bus.o_RX_DV    = rx_dv;
    assign bus.o_RX_Byte  = rx_byte;
    assign bus.o_SPI_Clk  = spi_clk;
    assign bus.o_SPI_MOSI = mosi;
`ifdef SPI_MASTER_CS_EN
    assign bus.o_SPI_CS_n = cs_n;
`endif

endmodule

// File: tb/tb_spi_master_mopshub.sv
// Self-checking bench: one DUT per SPI mode, all fed the same byte stream,
// MISO looped back to MOSI on each. Mode 3 is the timing reference.
module tb_spi_master_mopshub;

    localparam int N = 4;
`ifdef SPI_MASTER_CS_EN
    localparam int EXP_LAT = 16 * N + 1 + N;
`else
    localparam int EXP_LAT = 16 * N + 1;
`endif
    localparam logic [3:0] CPOL_V = 4'b1100;
    localparam logic [3:0] CPHA_V = 4'b1010;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       tx_dv = 1'b0;
    logic [7:0] tx_byte = 8'h00;

    logic [3:0] sclk, mosi, dv, rdy;
    logic [7:0] rxb [4];
`ifdef SPI_MASTER_CS_EN
    logic [3:0] cs;
`endif

    always #5 clk = ~clk;

    for (genvar g = 0; g < 4; g++) begin : g_dut
        spi_master_mopshub_if bus ();
        assign bus.i_TX_Byte  = tx_byte;
        assign bus.i_TX_DV    = tx_dv;
        assign bus.i_SPI_MISO = bus.o_SPI_MOSI;

        spi_master_mopshub #(.SPI_MODE(g), .CLKS_PER_HALF_BIT(N)) dut (
            .i_Clk   (clk),
            .i_Rst_L (rst),
            .bus     (bus)
        );

        assign sclk[g] = bus.o_SPI_Clk;
        assign mosi[g] = bus.o_SPI_MOSI;
        assign dv[g]   = bus.o_RX_DV;
        assign rdy[g]  = bus.o_TX_Ready;
        assign rxb[g]  = bus.o_RX_Byte;
`ifdef SPI_MASTER_CS_EN
        assign cs[g]   = bus.o_SPI_CS_n;
`endif
    end

    int checks = 0;
    int errors = 0;

    // Edge/pulse monitor: counts SCLK edges and RX_DV pulses, captures MOSI
    // on each mode's sampling edge, and checks mode-3 edge spacing.
    int         edges_total [4] = '{0, 0, 0, 0};
    int         dv_total [4]    = '{0, 0, 0, 0};
    logic [7:0] cap [4]         = '{8'h00, 8'h00, 8'h00, 8'h00};
    logic [3:0] prev_sclk = 4'b1100;
    int cyc = 0;
    int last_edge_cyc = 0;
    int xfer_edges = 0;
    int gap_err = 0;

    always @(negedge clk) begin
        cyc <= cyc + 1;
        prev_sclk <= sclk;
        for (int m = 0; m < 4; m++) begin
            if (sclk[m] != prev_sclk[m]) begin
                edges_total[m] <= edges_total[m] + 1;
                if ((prev_sclk[m] == CPOL_V[m]) == (CPHA_V[m] == 1'b0))
                    cap[m] <= {cap[m][6:0], mosi[m]};
            end
            if (dv[m]) dv_total[m] <= dv_total[m] + 1;
        end
        if (rst || rdy[3]) begin
            xfer_edges <= 0;
        end else if (sclk[3] != prev_sclk[3]) begin
            if (xfer_edges > 0 && (cyc - last_edge_cyc) != N) gap_err <= gap_err + 1;
            xfer_edges <= xfer_edges + 1;
            last_edge_cyc <= cyc;
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Called at a negedge or just after a posedge; returns just after the accepting edge.
    task automatic start_xfer(input logic [7:0] b);
        int n = 0;
        while (!rdy[3] && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("ready_before_start", int'(rdy[3]), 1);
        tx_byte = b;
        tx_dv = 1'b1;
        @(posedge clk);
        #1 tx_dv = 1'b0;
    endtask

    task automatic wait_done(output int lat);
        int rbad = 0;
        int cbad = 0;
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
            if (!dv[3]) begin
                if (rdy[3]) rbad++;
`ifdef SPI_MASTER_CS_EN
                if (cs[3] !== 1'b0) cbad++;
`endif
            end else begin
`ifdef SPI_MASTER_CS_EN
                if (cs[3] !== 1'b1) cbad++;
`endif
            end
        end while (!dv[3] && lat < 1000);
        chk("done_timeout", int'(dv[3]), 1);
        chk("ready_in_dv_cycle", int'(rdy[3]), 1);
        chk("ready_low_while_busy", rbad, 0);
        chk("cs_span", cbad, 0);
    endtask

    task automatic do_xfer(input logic [7:0] b, input logic [7:0] exp);
        int e0 [4];
        int d0 [4];
        int g0;
        int lat;
        e0 = edges_total;
        d0 = dv_total;
        g0 = gap_err;
        start_xfer(b);
        wait_done(lat);
        chk("latency", lat, EXP_LAT);
        repeat (3) @(negedge clk);
        chk("sclk_edge_spacing", gap_err - g0, 0);
        for (int m = 0; m < 4; m++) begin
            chk($sformatf("rx_byte_m%0d", m), int'(rxb[m]), int'(exp));
            chk($sformatf("mosi_bits_m%0d", m), int'(cap[m]), int'(exp));
            chk($sformatf("edges_m%0d", m), edges_total[m] - e0[m], 16);
            chk($sformatf("dv_pulses_m%0d", m), dv_total[m] - d0[m], 1);
            chk($sformatf("sclk_idle_m%0d", m), int'(sclk[m]), int'(CPOL_V[m]));
            chk($sformatf("mosi_hold_m%0d", m), int'(mosi[m]), int'(b[0]));
        end
    endtask

    typedef struct {
        logic [7:0] tx;
        logic [7:0] rx;
    } vec_t;
    vec_t vecs [6];

    initial begin
        int lat;
        int e0;
        int d0 [4];
        int n;

        vecs[0] = '{tx: 8'hC1, rx: 8'hC1};
        vecs[1] = '{tx: 8'h00, rx: 8'h00};
        vecs[2] = '{tx: 8'hFF, rx: 8'hFF};
        vecs[3] = '{tx: 8'h5A, rx: 8'h5A};
        vecs[4] = '{tx: 8'h81, rx: 8'h81};
        vecs[5] = '{tx: 8'h3C, rx: 8'h3C};

        // Reset held for 10 clocks.
        repeat (10) @(posedge clk);
        @(negedge clk);
        for (int m = 0; m < 4; m++) begin
            chk($sformatf("rst_sclk_m%0d", m), int'(sclk[m]), int'(CPOL_V[m]));
            chk($sformatf("rst_mosi_m%0d", m), int'(mosi[m]), 0);
            chk($sformatf("rst_ready_m%0d", m), int'(rdy[m]), 0);
            chk($sformatf("rst_dv_m%0d", m), int'(dv[m]), 0);
            chk($sformatf("rst_rxbyte_m%0d", m), int'(rxb[m]), 0);
`ifdef SPI_MASTER_CS_EN
            chk($sformatf("rst_cs_m%0d", m), int'(cs[m]), 1);
`endif
        end
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("ready_same_cycle_release", int'(rdy[3]), 0);
        @(negedge clk);
        chk("ready_after_release", int'(rdy[3]), 1);

        // Table-driven single transfers.
        for (int i = 0; i < 6; i++) do_xfer(vecs[i].tx, vecs[i].rx);

        // Back-to-back: second request issued in the RX_DV cycle of the first.
        d0 = dv_total;
        start_xfer(8'hBE);
        wait_done(lat);
        chk("b2b_first_byte", int'(rxb[3]), 8'hBE);
        start_xfer(8'hEF);
        wait_done(lat);
        chk("b2b_second_latency", lat, EXP_LAT);
        chk("b2b_second_byte", int'(rxb[3]), 8'hEF);
        chk("b2b_second_byte_m0", int'(rxb[0]), 8'hEF);
        repeat (3) @(negedge clk);
        chk("b2b_dv_pulses", dv_total[3] - d0[3], 2);

        // Request while busy is ignored.
        d0 = dv_total;
        e0 = edges_total[3];
        start_xfer(8'hA3);
        repeat (20) @(negedge clk);
        tx_byte = 8'h55;
        tx_dv = 1'b1;
        @(negedge clk);
        tx_dv = 1'b0;
        wait_done(lat);
        repeat (100) @(negedge clk);
        chk("ignore_rx_byte", int'(rxb[3]), 8'hA3);
        chk("ignore_rx_byte_m1", int'(rxb[1]), 8'hA3);
        chk("ignore_dv_pulses", dv_total[3] - d0[3], 1);
        chk("ignore_edges", edges_total[3] - e0, 16);
        chk("ignore_ready", int'(rdy[3]), 1);

        // Reset after 5 SCLK edges aborts the transfer.
        d0 = dv_total;
        e0 = edges_total[3];
        start_xfer(8'h3C);
        n = 0;
        while ((edges_total[3] - e0) < 5 && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("abort_edge_wait", int'(n < 200), 1);
        @(posedge clk);
        #1 rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        for (int m = 0; m < 4; m++) begin
            chk($sformatf("abort_sclk_m%0d", m), int'(sclk[m]), int'(CPOL_V[m]));
            chk($sformatf("abort_rxbyte_m%0d", m), int'(rxb[m]), 0);
        end
        chk("abort_mosi", int'(mosi[3]), 0);
        chk("abort_ready", int'(rdy[3]), 0);
        @(posedge clk);
        #1 rst = 1'b0;
        repeat (5) @(negedge clk);
        chk("abort_no_dv", dv_total[3] - d0[3], 0);
        do_xfer(8'h3C, 8'h3C);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/spi_master_mopshub.md
Name: spi_master_mopshub

Overview:
- Byte-oriented SPI master: serializes one 8-bit word onto MOSI, MSB first, and simultaneously deserializes 8 bits from MISO.
- SPI mode (CPOL/CPHA) and SCLK rate are set by parameters.
- Sits between MOPSHUB control logic and off-chip SPI peripherals.
- Single clock domain; SCLK is generated by dividing i_Clk.

Parameters:
- SPI_MODE, 3: 0..3; CPOL = SPI_MODE[1], CPHA = SPI_MODE[0].
- CLKS_PER_HALF_BIT, 4: i_Clk cycles per SCLK half-period; must be >= 2. SCLK frequency = f(i_Clk) / (2 * CLKS_PER_HALF_BIT).

Ports:
- i_Clk, input, 1: system clock; all logic on its rising edge.
- i_Rst_L, input, 1: reset, synchronous, active-high. The name follows the codebase; the polarity is high.
- i_TX_Byte, input, 8: byte to transmit; sampled when i_TX_DV is accepted.
- i_TX_DV, input, 1: single-cycle transmit request.
- o_TX_Ready, output, 1: high when idle and able to accept i_TX_DV.
- o_RX_DV, output, 1: single-cycle pulse; o_RX_Byte is valid.
- o_RX_Byte, output, 8: last received byte; held until the next transfer completes.
- o_SPI_Clk, output, 1: SPI serial clock.
- i_SPI_MISO, input, 1: serial data in.
- o_SPI_MOSI, output, 1: serial data out.

Behaviour:
- Reset (i_Rst_L=1 at a clock edge):
  - o_SPI_Clk=CPOL, o_SPI_MOSI=0, o_TX_Ready=0, o_RX_DV=0, o_RX_Byte=0.
  - Internal counters cleared; any transfer in progress is aborted with no o_RX_DV.
  - o_TX_Ready rises on the first clock after reset deasserts.
- Two states, IDLE and BUSY.
  - IDLE: o_TX_Ready=1, o_SPI_Clk=CPOL.
  - IDLE -> BUSY when i_TX_DV=1: i_TX_Byte is latched and o_TX_Ready=0 from the next cycle.
  - i_TX_DV in BUSY is ignored. The byte is neither queued nor latched.
- Edge generation:
  - Half-bit counter runs 0..2*CLKS_PER_HALF_BIT-1.
  - Leading edge when the count reaches CLKS_PER_HALF_BIT-1; trailing edge when it reaches 2*CLKS_PER_HALF_BIT-1.
  - o_SPI_Clk toggles on each edge.
  - Exactly 16 edges (8 SCLK periods) per byte; no gap between bits.
- Data, MSB first (bit index 7 down to 0):
  - CPHA=0: bit7 is driven on MOSI the cycle after acceptance. MOSI advances on each trailing edge; MISO is sampled on each leading edge.
  - CPHA=1: MOSI drives the next bit on each leading edge (bit7 on the first); MISO is sampled on each trailing edge.
- Completion:
  - The cycle after the 16th edge: o_SPI_Clk is back at CPOL and o_RX_DV=1 for exactly one cycle, with o_RX_Byte updated in the same cycle.
  - o_TX_Ready returns to 1 in that same cycle. A new i_TX_DV may then be accepted, so back-to-back bytes are allowed.
- Loopback (MISO tied to MOSI) returns the transmitted byte in every mode.
- o_SPI_MOSI holds its last driven value while IDLE.

Optional Feature:
SPI_MASTER_CS_EN
- Defined: adds port o_SPI_CS_n, output, 1, active-low chip select.
  - Reset value 1.
  - Driven 0 starting the cycle after i_TX_DV is accepted, through the 16th edge.
  - Returns to 1 in the o_RX_DV cycle.
  - The first SCLK edge is delayed by CLKS_PER_HALF_BIT cycles after CS_n falls (setup time).
- Undefined: no chip-select port and no extra delay; the block manages no slave select.

Test Plan:
- Mode 3, CLKS_PER_HALF_BIT=4, MISO looped to MOSI, hold reset 10 clocks then release:
  - o_SPI_Clk idles 1.
  - o_TX_Ready=1 one cycle after reset release.
  - All other outputs 0 during reset.
- Send 0xC1 -> o_TX_Ready low during transfer; 16 SCLK edges with 8-clock SCLK period; MOSI bits 1,1,0,0,0,0,0,1; o_RX_DV single pulse; o_RX_Byte=0xC1.
- Send 0xBE, then 0xEF immediately on ready -> o_RX_Byte=0xBE, then 0xEF; exactly one o_RX_DV pulse per byte.
- Pulse i_TX_DV with 0x55 mid-transfer of 0xA3 -> ignored; o_RX_Byte=0xA3; no extra transfer.
- Assert reset after 5 SCLK edges of 0x3C -> o_SPI_Clk returns to 1 (CPOL), no o_RX_DV, o_RX_Byte=0x00. A fresh 0x3C transfer then completes correctly.
- Repeat 0xC1 in modes 0, 1, 2 -> correct idle SCLK level, correct sample/launch edges, loopback byte 0xC1. With SPI_MASTER_CS_EN: o_SPI_CS_n low exactly spanning the transfer.
